fifo_serial_reader: RTL and testbench



---
 rtl/fifo_io_pkg.sv | 8 +
 rtl/bit_timer.sv | 15 +
 rtl/fifo_serial_reader.sv | 77 +++++++
 tb/tb_fifo_serial_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_io_pkg.sv
// fifo_io_pkg: shared state encoding and line levels for the FIFO serial reader
package fifo_io_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, START, DATA, STOP} state_t;
  localparam logic TX_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int FIFO_DATA_WIDTH = 4;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: reloadable down-counter that ticks while it sits at zero
module bit_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] load,
  output logic       tick
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (restart) cnt <= load;
    else if (cnt != '0) cnt <= cnt - 8'd1;
  assign tick = cnt == '0;
endmodule

// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader: pops FIFO words and sends each as a start/data/stop serial frame
module fifo_serial_reader
  import fifo_io_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BIT_CYCLES = 4,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_count
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic tick, restart, last_bit, stop_end;
  logic [7:0] load;
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
    case (state)
      IDLE: state_n = (en && !fifo_empty) ? READ : IDLE;
      READ: state_n = WAIT;
      WAIT: if (tick) begin
        state_n = START;
        shift_n = fifo_data;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        state_n = last_bit ? STOP : DATA;
        bit_cnt_n = last_bit ? bit_cnt : bit_cnt + BW'(1);
      end
      STOP: state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    stop_end = state == STOP && tick;
    // every phase change and every data-bit boundary starts a fresh count
    restart = state_n != state || (state == DATA && tick);
    load = state_n == WAIT ? 8'(RD_LATENCY - 1) : 8'(BIT_CYCLES - 1);
  end
  bit_timer u_timer (.clk(clk), .rst(rst), .restart(restart), .load(load), .tick(tick));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      fifo_rd_en <= 1'b0;
      tx <= TX_IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      fifo_rd_en <= state_n == READ;
      tx <= state_n == START ? START_BIT : state_n == DATA ? shift_n[0] : state_n == STOP ? STOP_BIT : TX_IDLE;
      busy <= state_n != IDLE;
      frame_done <= stop_end;
      frame_count <= frame_count + CNT_WIDTH'(stop_end);
    end
endmodule

// File: tb/tb_fifo_serial_reader.sv
// tb_fifo_serial_reader: FIFO model plus serial-line scoreboard for fifo_serial_reader
module tb_fifo_serial_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic fifo_empty = 1'b1;
  logic [3:0] fifo_data = 4'h0;
  logic fifo_rd_en, tx, busy, frame_done;
  logic [7:0] frame_count;
  logic en2 = 1'b0;
  logic empty2 = 1'b1;
  logic [3:0] data2 = 4'h9;
  logic rd2, tx2, busy2, done2;
  logic [7:0] fc2;
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int cyc = 0;
  int rd_cyc[$];
  logic [3:0] fifo_q[$];
  logic [3:0] exp_q[$];
  bit aborted = 1'b0;

  always #5 clk = ~clk;

  fifo_serial_reader dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  fifo_serial_reader #(.BIT_CYCLES(1), .RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(empty2), .fifo_data(data2),
    .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .frame_done(done2), .frame_count(fc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // FIFO model: pops on each sampled read strobe and queues the expected frame word
  always @(posedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      chk("rd_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) begin
        fifo_data <= fifo_q[0];
        exp_q.push_back(fifo_q.pop_front());
      end
      fifo_empty <= fifo_q.size() == 0;
    end
  end

  always @(posedge rst) aborted = 1'b1;

  // serial monitor: decodes each frame mid-bit and checks it against the scoreboard
  initial begin
    logic [3:0] w;
    logic stop;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        for (int i = 0; i < 4; i++) begin
          repeat (i == 0 ? 6 : 4) @(negedge clk);
          w[i] = tx;
        end
        repeat (4) @(negedge clk);
        stop = tx;
        if (aborted) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) chk("sb_unexpected_frame", 1, 0);
        else begin
          chk("sb_word", w, exp_q.pop_front());
          chk("sb_stop", stop, 1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_cnt = 0;
    rd_cyc.delete();
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_rd(input int n);
    int t = 0;
    while (rd_cnt < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_rd", rd_cnt >= n, 1);
  endtask

  task automatic wait_fc(input int n);
    int t = 0;
    while (frame_count != 8'(n) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("wait_frame_count", frame_count, n);
  endtask

  initial begin
    logic [28:1] tx_v, rd_v, done_v, busy_v;
    logic [12:1] tx2_v, rd2_v, done2_v;
    logic [7:0] fc2_k11;
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:1] tx_v, rd_v, done_v, busy_v;
    logic [12:1] tx2_v, rd2_v, done2_v;
    logic [7:0] fc2_k11;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", frame_count, 0);
    rst = 1'b0;
    en = 1'b1;
    repeat (20) @(negedge clk);
    chk("empty_no_read", rd_cnt, 0);
    // single frame 0xA, cycle-by-cycle
    push(4'hA);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      tx_v[k] = tx;
      rd_v[k] = fifo_rd_en;
      done_v[k] = frame_done;
      busy_v[k] = busy;
    end
    chk("single_tx", tx_v, 28'b1111111111_0000_1111_00000000_11);
    chk("single_rd_en", rd_v, 28'h0000001);
    chk("single_done", done_v, 28'h4000000);
    chk("single_busy", busy_v, 28'h3FFFFFF);
    chk("single_count", frame_count, 1);
    // back-to-back frames
    do_reset();
    push(4'h3);
    push(4'hC);
    push(4'h5);
    wait_fc(3);
    repeat (3) @(negedge clk);
    chk("b2b_reads", rd_cnt, 3);
    chk("b2b_gap1", rd_cyc.size() == 3 ? rd_cyc[1] - rd_cyc[0] : 0, 27);
    chk("b2b_gap2", rd_cyc.size() == 3 ? rd_cyc[2] - rd_cyc[1] : 0, 27);
    chk("b2b_busy_low", busy, 0);
    chk("b2b_count", frame_count, 3);
    // en dropped during DATA
    do_reset();
    push(4'h6);
    push(4'h7);
    wait_rd(1);
    repeat (11) @(negedge clk);
    chk("en_drop_in_frame", busy, 1);
    en = 1'b0;
    repeat (40) @(negedge clk);
    chk("en_drop_reads", rd_cnt, 1);
    chk("en_drop_count", frame_count, 1);
    en = 1'b1;
    wait_rd(2);
    wait_fc(2);
    // reset during DATA
    do_reset();
    push(4'h8);
    wait_rd(1);
    repeat (11) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_reread", rd_cnt, 1);
    chk("rst_count", frame_count, 0);
    push(4'hB);
    wait_rd(2);
    wait_fc(1);
    repeat (10) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    // BIT_CYCLES=1, RD_LATENCY=3 instance
    en2 = 1'b1;
    empty2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tx2_v[k] = tx2;
      rd2_v[k] = rd2;
      done2_v[k] = done2;
      if (k == 11) fc2_k11 = fc2;
      if (k == 1) empty2 = 1'b1;
      if (k == 2) empty2 = 1'b0;
    end
    empty2 = 1'b1;
    en2 = 1'b0;
    chk("fast_rd_en", rd2_v, 12'h801);
    chk("fast_tx", tx2_v, 12'hF2F);
    chk("fast_done", done2_v, 12'h400);
    chk("fast_count", fc2_k11, 1);
    repeat (15) @(negedge clk);
    chk("fast_count2", fc2, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
